// File: rtl/frame_parse_pkg.sv
// Shared types and constants for the Ethernet-style frame parser.
package frame_parse_pkg;

  // Parser states; the encoding is left to the enum.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CHECK,
    ST_ERROR,
    ST_DRAIN
  } state_t;

  // Error codes reported on error_code.
  localparam logic [1:0] ERR_PREAMBLE = 2'b00;
  localparam logic [1:0] ERR_ABORT    = 2'b01;
  localparam logic [1:0] ERR_RUNT     = 2'b10;
  localparam logic [1:0] ERR_GIANT    = 2'b11;

  // Framing bytes and field lengths.
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned PREAMBLE_LEN  = 7;
  localparam int unsigned HEADER_LEN    = 14;

  // Width of the payload+CRC byte counter.
  localparam int unsigned BYTE_CNT_W = 11;

  // The payload/CRC stage is enabled while payload bytes flow and during the check cycle.
  function automatic logic stage_enabled(input state_t s);
    return (s == ST_PAYLOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/frame_parse_ctrl.sv
// Frame parser control: preamble/SFD detection, header capture, payload length
// policing and frame accept/reject pulses. The payload/CRC stage is external.
module frame_parse_ctrl
  import frame_parse_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 1504
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_valid,
  input  logic [7:0]  data_in,
  input  logic        packet_size_valid,
  output logic        payload_enable,
  output logic        frame_done,
  output logic        frame_error,
  output logic [1:0]  error_code,
  output logic [15:0] length_field
);

  localparam logic [2:0]            PRE_FULL  = 3'(PREAMBLE_LEN);
  localparam logic [3:0]            HDR_LEN_H = 4'(HEADER_LEN - 2);
  localparam logic [3:0]            HDR_LAST  = 4'(HEADER_LEN - 1);
  localparam logic [BYTE_CNT_W-1:0] BYTE_MAX  = BYTE_CNT_W'(MAX_BYTES);

  state_t                r_state;
  state_t                w_next_state;
  logic [2:0]            r_pre_cnt;
  logic [3:0]            r_hdr_cnt;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [15:0]           r_shadow;
  logic [15:0]           r_length;
  logic [1:0]            r_err_code;
  logic                  r_done;
  logic [1:0]            w_err_code;
  logic                  w_accept;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode; w_err_code is the code latched whenever ERROR is entered.
  always_comb begin
    w_next_state = r_state;
    w_err_code   = ERR_PREAMBLE;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (data_valid) begin
          if (data_in == PREAMBLE_BYTE) begin
            w_next_state = ST_PREAMBLE;
          end else begin
            w_next_state = ST_ERROR;
            w_err_code   = ERR_PREAMBLE;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!data_valid) begin
          w_next_state = ST_ERROR;
          w_err_code   = ERR_ABORT;
        end else if ((data_in == PREAMBLE_BYTE) && (r_pre_cnt < PRE_FULL)) begin
          w_next_state = ST_PREAMBLE;
        end else if ((data_in == SFD_BYTE) && (r_pre_cnt == PRE_FULL)) begin
          w_next_state = ST_HEADER;
        end else begin
          w_next_state = ST_ERROR;
          w_err_code   = ERR_PREAMBLE;
        end
      end
      ST_HEADER: begin
        if (!data_valid) begin
          w_next_state = ST_ERROR;
          w_err_code   = ERR_ABORT;
        end else if (r_hdr_cnt == HDR_LAST) begin
          w_next_state = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!data_valid) begin
          w_next_state = ST_CHECK;
        end else if (r_byte_cnt == BYTE_MAX) begin
          // MAX_BYTES already counted, so this byte is one too many.
          w_next_state = ST_ERROR;
          w_err_code   = ERR_GIANT;
        end
      end
      ST_CHECK: begin
        if (packet_size_valid) begin
          w_next_state = ST_IDLE;
          w_accept     = 1'b1;
        end else begin
          w_next_state = ST_ERROR;
          w_err_code   = ERR_RUNT;
        end
      end
      ST_ERROR: begin
        w_next_state = data_valid ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (!data_valid) w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Byte counters and header shadow; counters idle at zero outside their own state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pre_cnt  <= '0;
      r_hdr_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shadow   <= '0;
    end else begin
      r_pre_cnt  <= '0;
      r_hdr_cnt  <= '0;
      r_byte_cnt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (data_valid) r_pre_cnt <= 3'd1;
        end
        ST_PREAMBLE: begin
          if (data_valid) r_pre_cnt <= r_pre_cnt + 3'd1;
        end
        ST_HEADER: begin
          if (data_valid) begin
            r_hdr_cnt <= r_hdr_cnt + 4'd1;
            if (r_hdr_cnt == HDR_LEN_H) r_shadow[15:8] <= data_in;
            if (r_hdr_cnt == HDR_LAST)  r_shadow[7:0]  <= data_in;
          end
        end
        ST_PAYLOAD: begin
          if (data_valid) r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers: accept pulse, published length, sticky error code.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_done     <= 1'b0;
      r_length   <= '0;
      r_err_code <= ERR_PREAMBLE;
    end else begin
      r_done <= w_accept;
      if (w_accept) r_length <= r_shadow;
      if (w_next_state == ST_ERROR) r_err_code <= w_err_code;
    end
  end

  assign payload_enable = stage_enabled(r_state);
  assign frame_error    = (r_state == ST_ERROR);
  assign frame_done     = r_done;
  assign error_code     = r_err_code;
  assign length_field   = r_length;

endmodule
